// File: rtl/operand_entry_seq_if.sv
// Board-side bundle for the operand entry stage: raw keys and switches in,
// captured operand set and user prompt stage out.
interface operand_entry_seq_if;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       cin_out;
  logic       mode_out;
  logic       valid;
  logic [1:0] stage;

  modport master (
    output KEY,
    output SW,
    input  a_out,
    input  b_out,
    input  cin_out,
    input  mode_out,
    input  valid,
    input  stage
  );

  modport slave (
    input  KEY,
    input  SW,
    output a_out,
    output b_out,
    output cin_out,
    output mode_out,
    output valid,
    output stage
  );
endinterface

// File: rtl/operand_entry_seq.sv
// Debounces enter/abort push-buttons and steps the user through capturing
// operand A, then operand B with carry-in and mode, holding the result stable.
module operand_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  operand_entry_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [1:0]       press_q;
  logic [1:0]       press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  state_t     state_q;
  state_t     state_d;
  logic [3:0] a_q;
  logic [3:0] a_d;
  logic [3:0] b_q;
  logic [3:0] b_d;
  logic       cin_q;
  logic       cin_d;
  logic       mode_q;
  logic       mode_d;
  logic       valid_q;
  logic       valid_d;

  logic enterPulse;
  logic abortPulse;

  // Keys idle high, so the synchroniser and debounced levels reset to released.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      deb_q    <= 2'b11;
      press_q  <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= bus.KEY;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // A level is accepted only after it has differed for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    deb_d   = deb_q;
    press_d = 2'b00;
    cnt_d[0] = '0;
    cnt_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
      press_d[i] = deb_q[i] & ~deb_d[i];
    end
  end

  assign enterPulse = press_q[0];
  assign abortPulse = press_q[1];

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= LOAD_A;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      cin_q   <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
    end
  end

  // Abort has priority over enter when both pulses land in the same cycle.
  always_comb begin
    state_d = state_q;
    if (abortPulse) begin
      state_d = LOAD_A;
    end else if (enterPulse) begin
      case (state_q)
        LOAD_A:  state_d = LOAD_B;
        LOAD_B:  state_d = SHOW;
        SHOW:    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    if (abortPulse) begin
      valid_d = 1'b0;
    end else if (enterPulse) begin
      case (state_q)
        LOAD_A: begin
          a_d     = bus.SW[3:0];
          valid_d = 1'b0;
        end
        LOAD_B: begin
          b_d     = bus.SW[3:0];
          cin_d   = bus.SW[8];
          mode_d  = bus.SW[9];
          valid_d = 1'b1;
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.cin_out  = cin_q;
  assign bus.mode_out = mode_q;
  assign bus.valid    = valid_q;
  assign bus.stage    = state_q;

endmodule

// File: tb/tb_operand_entry_seq.sv
// Directed bench for operand_entry_seq with a short debounce window; expected
// operand sets are queued as keys are driven and compared once the DUT settles.
module tb_operand_entry_seq;

  typedef struct packed {
    logic [1:0] stage;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       mode;
    logic       valid;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t model;
  exp_t sb [$];

  operand_entry_seq_if bus ();

  operand_entry_seq #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkField(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    model = '0;
    sb.push_back(model);
  endtask

  task automatic modelEnter(input logic [9:0] sw);
    case (model.stage)
      2'b00: begin
        model.a     = sw[3:0];
        model.stage = 2'b01;
      end
      2'b01: begin
        model.b     = sw[3:0];
        model.cin   = sw[8];
        model.mode  = sw[9];
        model.valid = 1'b1;
        model.stage = 2'b10;
      end
      default: begin
        model.valid = 1'b0;
        model.stage = 2'b00;
      end
    endcase
    sb.push_back(model);
  endtask

  task automatic modelAbort();
    model.valid = 1'b0;
    model.stage = 2'b00;
    sb.push_back(model);
  endtask

  task automatic modelHold();
    sb.push_back(model);
  endtask

  task automatic applyStimulus(input logic [1:0] keyLevel, input int lowCycles, input logic [9:0] sw);
    bus.SW = sw;
    @(posedge clk);
    #1 bus.KEY = keyLevel;
    repeat (lowCycles) @(posedge clk);
    #1 bus.KEY = 2'b11;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed empty scoreboard expected entry", tag);
    end else begin
      exp = sb.pop_front();
      @(negedge clk);
      for (int k = 0; k < 40 && bus.stage !== exp.stage; k++) @(negedge clk);
      checkField({tag, ".stage"}, {2'b00, bus.stage}, {2'b00, exp.stage});
      checkField({tag, ".a"},     bus.a_out,          exp.a);
      checkField({tag, ".b"},     bus.b_out,          exp.b);
      checkField({tag, ".cin"},   {3'b000, bus.cin_out},  {3'b000, exp.cin});
      checkField({tag, ".mode"},  {3'b000, bus.mode_out}, {3'b000, exp.mode});
      checkField({tag, ".valid"}, {3'b000, bus.valid},    {3'b000, exp.valid});
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    model   = '0;
    reset   = 1'b1;
    bus.KEY = 2'b11;
    bus.SW  = 10'h000;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    checkOutput("reset");

    // Full entry A then B with carry-in and add mode
    applyStimulus(2'b10, 8, 10'h005);
    modelEnter(10'h005);
    checkOutput("loadA");
    applyStimulus(2'b10, 8, 10'h303);
    modelEnter(10'h303);
    checkOutput("loadB");

    // Switch movement in SHOW must not reach the outputs
    bus.SW = 10'h3FF;
    repeat (20) @(posedge clk);
    #1;
    modelHold();
    checkOutput("holdShow");
    applyStimulus(2'b10, 8, 10'h3FF);
    modelEnter(10'h3FF);
    checkOutput("leaveShow");

    // Bounce shorter than the window, then a long hold advancing once
    applyStimulus(2'b10, 3, 10'h00A);
    modelHold();
    checkOutput("bounce");
    applyStimulus(2'b10, 10, 10'h00A);
    modelEnter(10'h00A);
    checkOutput("longHold");
    repeat (20) @(posedge clk);
    modelHold();
    checkOutput("noRepeat");

    // Enter and abort together in LOAD_B
    applyStimulus(2'b00, 8, 10'h0F7);
    modelAbort();
    checkOutput("abort");

    // Reset in the middle of a debounce with the key still held
    bus.SW = 10'h00C;
    @(posedge clk);
    #1 bus.KEY = 2'b10;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    modelReset();
    checkOutput("midReset");
    repeat (3) @(posedge clk);
    #1;
    modelHold();
    checkOutput("noEarlyEvent");
    modelEnter(10'h00C);
    checkOutput("afterReset");
    repeat (20) @(posedge clk);
    modelHold();
    checkOutput("heldAfterReset");
    #1 bus.KEY = 2'b11;
    repeat (10) @(posedge clk);
    modelHold();
    checkOutput("released");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
